// File: rtl/key_filter_pkg.sv
// Shared constants for the elevator panel key conditioner: channel count,
// key index map and the sample-tick divider calculation.
package key_filter_pkg;

  localparam int N_KEYS_DEF = 10;

  // Hall calls first, then cabin "to floor" keys.
  localparam int UP1   = 0;
  localparam int UP2   = 1;
  localparam int UP3   = 2;
  localparam int DOWN2 = 3;
  localparam int DOWN3 = 4;
  localparam int DOWN4 = 5;
  localparam int TO1   = 6;
  localparam int TO2   = 7;
  localparam int TO3   = 8;
  localparam int TO4   = 9;

  function automatic int calc_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

endpackage

// File: rtl/key_filter_debounce_ch.sv
// One key channel: two-flop synchronizer, tick-sampled debounce counter,
// debounced level, rising-edge press pulse and pending-request latch.
module debounce_ch
  import key_filter_pkg::*;
#(
  parameter int STABLE_CNT = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic key_i,
  input  logic clr_i,
  output logic level_o,
  output logic press_o,
  output logic req_o
);

  localparam int CW = $clog2(STABLE_CNT) + 1;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q, press_d;
  logic          req_q, req_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(STABLE_CNT - 1)) begin
        // STABLE_CNT-th consecutive differing sample: accept the new level.
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = level_q & ~level_dly_q;
    // A press arriving together with a clear must not be lost.
    req_d   = press_q | (req_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      sync1_q     <= key_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
      req_q       <= req_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign req_o   = req_q;

endmodule

// File: rtl/key_filter.sv
// Elevator panel key conditioner: shared sample-tick divider feeding one
// debounce channel per key; key_any summarises pending requests.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int N_KEYS     = N_KEYS_DEF,
  parameter int CLK_HZ     = 100000000,
  parameter int SAMPLE_HZ  = 1000,
  parameter int STABLE_CNT = 8
) (
  input  logic              clk100mhz,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] key_clr,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_req,
  output logic              key_any
);

  localparam int DIV = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam int DW  = $clog2(DIV);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick;

  always_comb begin
    tick      = (div_cnt_q == DW'(DIV - 1));
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
  end

  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT(STABLE_CNT)
    ) u_ch (
      .clk_i  (clk100mhz),
      .rst_ni (reset),
      .tick_i (tick),
      .key_i  (key_in[i]),
      .clr_i  (key_clr[i]),
      .level_o(key_level[i]),
      .press_o(key_press[i]),
      .req_o  (key_req[i])
    );
  end

  assign key_any = |key_req;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: directed scenarios plus random key/clear traffic,
// checked every cycle against a sample-history reference model.
module tb_key_filter;
  import key_filter_pkg::*;

  localparam int N         = 10;
  localparam int CLK_HZ    = 1000;
  localparam int SAMPLE_HZ = 100;
  localparam int STABLE    = 8;
  localparam int DIV       = CLK_HZ / SAMPLE_HZ;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] key_in, key_clr;
  logic [N-1:0] key_level, key_press, key_req;
  logic         key_any;

  key_filter #(
    .N_KEYS    (N),
    .CLK_HZ    (CLK_HZ),
    .SAMPLE_HZ (SAMPLE_HZ),
    .STABLE_CNT(STABLE)
  ) dut (
    .clk100mhz(clk),
    .reset    (rst_n),
    .key_in   (key_in),
    .key_clr  (key_clr),
    .key_level(key_level),
    .key_press(key_press),
    .key_req  (key_req),
    .key_any  (key_any)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: level flips once the last STABLE tick samples all differ
  int                n_edge;
  logic [N-1:0]      in_d1, in_d2;
  logic [N-1:0]      m_level, m_rose, m_press, m_req;
  logic [STABLE-1:0] hist [N];
  logic [N-1:0]      exp_q [$];
  int                press_cnt [N];
  int                req_cnt [N];

  task automatic model_reset();
    n_edge  = 0;
    in_d1   = '0;
    in_d2   = '0;
    m_level = '0;
    m_rose  = '0;
    m_press = '0;
    m_req   = '0;
    for (int i = 0; i < N; i++) hist[i] = '0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [N-1:0] kin, input logic [N-1:0] kclr);
    logic [N-1:0] new_level;
    new_level = m_level;
    n_edge++;
    if (n_edge % DIV == 0) begin
      for (int i = 0; i < N; i++) begin
        hist[i] = {hist[i][STABLE-2:0], in_d2[i]};
        if (hist[i] == {STABLE{~m_level[i]}}) new_level[i] = ~m_level[i];
      end
    end
    m_req   = m_press | (m_req & ~kclr);
    m_press = m_rose;
    m_rose  = new_level & ~m_level;
    m_level = new_level;
    in_d2   = in_d1;
    in_d1   = kin;
    if (m_press != '0) exp_q.push_back(m_press);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0;
      req_cnt[i]   = 0;
    end
  endtask

  // driver: one clock, model update at the edge, outputs checked on negedge
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(key_in, key_clr);
    @(negedge clk);
    chk("level", 32'(key_level), 32'(m_level));
    chk("press", 32'(key_press), 32'(m_press));
    chk("req",   32'(key_req),   32'(m_req));
    chk("any",   32'(key_any),   32'(|m_req));
    if (key_press != '0) begin
      if (exp_q.size() > 0) chk("press_sb", 32'(key_press), 32'(exp_q.pop_front()));
      else                  chk("press_sb_extra", 32'(key_press), 32'd0);
    end
    for (int i = 0; i < N; i++) begin
      if (key_press[i]) press_cnt[i]++;
      if (key_req[i])   req_cnt[i]++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int sum;
    rst_n   = 1'b0;
    key_in  = '1;
    key_clr = '0;
    model_reset();
    clear_counts();

    // reset with all keys held, then release
    run(3);
    chk("rst_level", 32'(key_level), 32'd0);
    chk("rst_req",   32'(key_req),   32'd0);
    rst_n = 1'b1;
    run(DIV * STABLE + 20);
    chk("rel_level", 32'(key_level), 32'h3FF);
    chk("rel_req",   32'(key_req),   32'h3FF);
    chk("rel_any",   32'(key_any),   32'd1);
    for (int i = 0; i < N; i++) chk($sformatf("rel_press%0d", i), 32'(press_cnt[i]), 32'd1);
    key_in  = '0;
    key_clr = '1;
    run(1);
    key_clr = '0;
    run(120);
    chk("clr_all", 32'(key_req), 32'd0);

    // glitch of 7 ticks on TO1
    clear_counts();
    key_in[TO1] = 1'b1;
    run(7 * DIV);
    key_in[TO1] = 1'b0;
    run(120);
    chk("glitch_level", 32'(key_level[TO1]), 32'd0);
    chk("glitch_press", 32'(press_cnt[TO1]), 32'd0);
    chk("glitch_req",   32'(key_req[TO1]),   32'd0);

    // clean press and single-cycle clear on UP3
    clear_counts();
    key_in[UP3] = 1'b1;
    run(200);
    chk("clean_press", 32'(press_cnt[UP3]), 32'd1);
    chk("clean_req",   32'(key_req[UP3]),   32'd1);
    key_clr[UP3] = 1'b1;
    run(1);
    key_clr[UP3] = 1'b0;
    chk("clean_clr", 32'(key_req[UP3]), 32'd0);
    chk("clean_any", 32'(key_any),      32'd0);
    key_in[UP3] = 1'b0;
    run(120);

    // press on TO4 while its clear is held
    clear_counts();
    key_clr[TO4] = 1'b1;
    key_in[TO4]  = 1'b1;
    run(200);
    chk("coll_press", 32'(press_cnt[TO4]), 32'd1);
    chk("coll_req_cycles", 32'(req_cnt[TO4]), 32'd1);
    key_in[TO4] = 1'b0;
    run(120);
    key_clr = '0;

    // bounce on UP1 every 3 ticks, then hold
    clear_counts();
    for (int s = 0; s < 10; s++) begin
      key_in[UP1] = (s % 2 == 0);
      run(3 * DIV);
    end
    key_in[UP1] = 1'b1;
    run(150);
    chk("bounce_press", 32'(press_cnt[UP1]), 32'd1);
    key_in[UP1] = 1'b0;
    run(120);

    // asynchronous reset mid-operation
    key_in = 10'h041;
    run(120);
    chk("pre_rst_req", 32'(key_req), 32'h041);
    key_in[DOWN2] = 1'b1;
    run(4 * DIV);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_level", 32'(key_level), 32'd0);
    chk("async_req",   32'(key_req),   32'd0);
    chk("async_any",   32'(key_any),   32'd0);
    key_in = '0;
    run(3);
    rst_n = 1'b1;
    clear_counts();
    run(150);
    sum = 0;
    for (int i = 0; i < N; i++) sum += press_cnt[i];
    chk("post_rst_press", 32'(sum), 32'd0);

    // random key and clear traffic
    for (int s = 0; s < 60; s++) begin
      key_in  = N'($urandom_range(0, 1023));
      key_clr = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 1023)) : '0;
      run($urandom_range(5, 160));
    end
    key_in  = '0;
    key_clr = '0;
    run(120);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
